vec_load_unit: RTL
==================

VEC_LOAD_UNIT -- requirements
Module: vec_load_unit

Interface
REQ-001 Parameters SHALL be: registerSize, default 8, lane width in bits; ADDR_W, default 16, data-memory address width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 reqValid  input  1  load request present.
REQ-005 reqReady  output  1  unit can accept a request.
REQ-006 reqAddr  input  ADDR_W  base byte address of lane 0.
REQ-007 reqReg  input  3  destination vector register index.
REQ-008 memRdEn  output  1  data-memory read strobe.
REQ-009 memAddr  output  ADDR_W  data-memory read address.
REQ-010 memRdData  input  registerSize  read data, valid exactly one cycle after memRdEn.
REQ-011 regWrEn  output  1  vector register-file write enable, one-cycle pulse.
REQ-012 regToWrite  output  3  destination register index for the write.
REQ-013 regWriteData_0..regWriteData_3  output  registerSize each  assembled lanes 0..3.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, DRAIN and WRITE.
REQ-016 reqReady SHALL equal (state == IDLE); a request SHALL be accepted on a cycle where reqValid and reqReady are both high.
REQ-017 On acceptance, reqAddr and reqReg SHALL be latched and the FSM SHALL move to ISSUE with lane counter = 0.
REQ-018 In ISSUE, memRdEn SHALL be 1 and memAddr SHALL be the latched base plus k*stride for lane k = 0..3, one lane per cycle (4 cycles); the sum SHALL wrap modulo 2^ADDR_W.
REQ-019 memRdData SHALL be captured into lane k on the cycle after lane k is issued.
REQ-020 DRAIN SHALL last 1 cycle with memRdEn = 0 and SHALL capture lane 3.
REQ-021 WRITE SHALL last 1 cycle with regWrEn = 1 and regToWrite = the latched reqReg; all four lane outputs SHALL be valid in that cycle, and the FSM SHALL then return to IDLE.
REQ-022 Latency SHALL be: acceptance at cycle 0, memRdEn high on cycles 1-4, regWrEn high on cycle 6, reqReady high again on cycle 7.
REQ-023 reqValid SHALL be ignored outside IDLE; request inputs SHALL NOT need to be held after acceptance.
REQ-024 regWrEn SHALL be 0 in every state other than WRITE; regWriteData_* SHALL hold their last values between writes.
REQ-025 memAddr SHALL be 0 whenever memRdEn is 0.

Reset
REQ-026 Reset SHALL force state IDLE, lane counter 0, latched address and register 0, and all lane registers 0.
REQ-027 Output values during and immediately after reset SHALL be: reqReady = 1, busy = 0, memRdEn = 0, memAddr = 0, regWrEn = 0, regToWrite = 0, regWriteData_* = 0.
REQ-028 A reset asserted mid-operation SHALL abort the load, and no regWrEn pulse SHALL follow it.

Configuration
REQ-029 With VEC_LOAD_STRIDE_EN defined, an input reqStride (ADDR_W bits) SHALL exist and be latched at acceptance as the per-lane stride.
REQ-030 Without VEC_LOAD_STRIDE_EN, the reqStride port SHALL be absent and the stride SHALL be the constant 1.

Structure
REQ-031 Package vec_pkg SHALL hold the LANES = 4 constant, the FSM state enum and the lane index typedef.
REQ-032 Lane capture SHALL be a sub-module vec_lane_collector, holding 4 registerSize registers written by lane index, with an asynchronous reset.

Verification
REQ-033 Load with reqAddr = 0x0010, reqReg = 3 and memory[0x10..0x13] = 11,22,33,44 -> memAddr 0x10-0x13 on cycles 1-4; regWrEn on cycle 6 with regToWrite = 3 and lanes = 11,22,33,44.
REQ-034 reqValid held high continuously -> acceptances on cycles 0 and 7 only; second regWrEn on cycle 13.
REQ-035 reqAddr = 0xFFFE -> memAddr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-036 Reset pulsed on cycle 3 of a load -> no regWrEn pulse, outputs return to the REQ-027 values, and reqReady = 1 on the first cycle after reset deasserts.
REQ-037 With VEC_LOAD_STRIDE_EN defined, reqAddr = 0x0100 and reqStride = 4 -> memAddr sequence 0x100, 0x104, 0x108, 0x10C.
REQ-038 reqAddr changed while busy -> memAddr sequence and written lanes unaffected.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared constants and types for the vector load unit: lane count, FSM states, lane index.
package vec_pkg;
  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WRITE
  } state_t;

  typedef logic [1:0] lane_idx_t;
endpackage

// File: rtl/vec_lane_collector.sv
// Four lane registers for an in-flight vector load, each written when its lane index is presented.
module vec_lane_collector
  import vec_pkg::*;
#(
  parameter int registerSize = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  lane_idx_t               wr_idx,
  input  logic [registerSize-1:0] wr_data,
  output logic [registerSize-1:0] lane_data [LANES]
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [registerSize-1:0] lane_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lane_reg <= '0;
      end else if (wr_en && (wr_idx == lane_idx_t'(gi))) begin
        lane_reg <= wr_data;
      end
    end

    assign lane_data[gi] = lane_reg;
  end

endmodule

// File: rtl/vec_load_unit.sv
// Vector load unit: reads four lanes from data memory and writes them to one vector register.
// Define VEC_LOAD_STRIDE_EN to add a per-request reqStride input; otherwise lanes are consecutive.
module vec_load_unit
  import vec_pkg::*;
#(
  parameter int registerSize = 8,
  parameter int ADDR_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic [ADDR_W-1:0]       reqAddr,
  input  logic [2:0]              reqReg,
`ifdef VEC_LOAD_STRIDE_EN
  input  logic [ADDR_W-1:0]       reqStride,
`endif
  output logic                    memRdEn,
  output logic [ADDR_W-1:0]       memAddr,
  input  logic [registerSize-1:0] memRdData,
  output logic                    regWrEn,
  output logic [2:0]              regToWrite,
  output logic [registerSize-1:0] regWriteData_0,
  output logic [registerSize-1:0] regWriteData_1,
  output logic [registerSize-1:0] regWriteData_2,
  output logic [registerSize-1:0] regWriteData_3,
  output logic                    busy
);

  state_t                  state_reg, state_next;
  lane_idx_t               lane_reg, lane_next;
  logic [ADDR_W-1:0]       base_reg;
  logic [2:0]              reg_idx_reg;
  logic [ADDR_W-1:0]       stride;
  logic [ADDR_W-1:0]       lane_off;
  logic                    accept;
  logic                    cap_en;
  lane_idx_t               cap_idx;
  logic [registerSize-1:0] lane_data [LANES];
  logic [registerSize-1:0] hold_reg  [LANES];
  logic [registerSize-1:0] out_data  [LANES];

  assign accept = reqValid && (state_reg == IDLE);

`ifdef VEC_LOAD_STRIDE_EN
  logic [ADDR_W-1:0] stride_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stride_reg <= '0;
    end else if (accept) begin
      stride_reg <= reqStride;
    end
  end

  assign stride = stride_reg;
`else
  assign stride = ADDR_W'(1);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      lane_reg    <= '0;
      base_reg    <= '0;
      reg_idx_reg <= '0;
    end else begin
      state_reg <= state_next;
      lane_reg  <= lane_next;
      if (accept) begin
        base_reg    <= reqAddr;
        reg_idx_reg <= reqReg;
      end
    end
  end

  // Read data lags the issue by one cycle, so ISSUE captures the previous lane and DRAIN the last.
  always_comb begin
    state_next = state_reg;
    lane_next  = lane_reg;
    memRdEn    = 1'b0;
    regWrEn    = 1'b0;
    cap_en     = 1'b0;
    cap_idx    = lane_reg - 2'd1;
    case (state_reg)
      IDLE: begin
        if (reqValid) begin
          state_next = ISSUE;
          lane_next  = '0;
        end
      end
      ISSUE: begin
        memRdEn   = 1'b1;
        cap_en    = (lane_reg != 2'd0);
        lane_next = lane_reg + 2'd1;
        if (lane_reg == 2'd3) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        cap_en     = 1'b1;
        cap_idx    = 2'd3;
        state_next = WRITE;
      end
      WRITE: begin
        regWrEn    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign lane_off = ADDR_W'(lane_reg) * stride;
  assign memAddr  = memRdEn ? (base_reg + lane_off) : '0;

  vec_lane_collector #(
    .registerSize(registerSize)
  ) u_collector (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (cap_en),
    .wr_idx   (cap_idx),
    .wr_data  (memRdData),
    .lane_data(lane_data)
  );

  // Lane registers refill during the next load, so outputs come from a bank committed at WRITE.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_out
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hold_reg[gi] <= '0;
      end else if (state_reg == WRITE) begin
        hold_reg[gi] <= lane_data[gi];
      end
    end

    assign out_data[gi] = (state_reg == WRITE) ? lane_data[gi] : hold_reg[gi];
  end

  assign regWriteData_0 = out_data[0];
  assign regWriteData_1 = out_data[1];
  assign regWriteData_2 = out_data[2];
  assign regWriteData_3 = out_data[3];

  assign regToWrite = reg_idx_reg;
  assign reqReady   = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);

endmodule
